// File: rtl/i2c_master_pkg.sv
// Shared command codes and FSM state encodings for the I2C master.
package i2c_master_pkg;

  typedef enum logic [2:0] {
    CMD_START   = 3'b001,
    CMD_WR      = 3'b010,
    CMD_RD      = 3'b011,
    CMD_STOP    = 3'b100,
    CMD_RESTART = 3'b101
  } cmd_e;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_START1   = 4'd1,
    ST_START2   = 4'd2,
    ST_HOLD     = 4'd3,
    ST_DATA1    = 4'd4,
    ST_DATA2    = 4'd5,
    ST_DATA3    = 4'd6,
    ST_DATA4    = 4'd7,
    ST_DATA_END = 4'd8,
    ST_RESTART  = 4'd9,
    ST_STOP1    = 4'd10,
    ST_STOP2    = 4'd11
  } state_e;

  localparam logic [4:0] ACK_SLOT = 5'd8;

endpackage

// File: rtl/i2c_open_drain.sv
// Open-drain pad: the line is pulled low or left floating, never driven high.
module i2c_open_drain (
  input logic drive_low,
  inout wire  line
);

  assign line = drive_low ? 1'b0 : 1'bz;

endmodule

// File: rtl/i2c_master_controller.sv
// Command-driven I2C master: START/WR/RD/STOP/RESTART, one SCL quarter per state.
module i2c_master_controller
  import i2c_master_pkg::*;
#(
  parameter int DVSR = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_wr_i2c,
  input  logic [2:0] i_cmd,
  input  logic [7:0] i_din,
  output logic [7:0] o_dout,
  output logic       o_ack,
  output logic       o_ready,
  output logic       o_done_tick,
  output logic [3:0] o_state,
  output logic [4:0] o_bit_count,
  inout  wire        io_sda,
  inout  wire        io_scl
);

  state_e      state, state_next;
  logic [15:0] cnt;
  logic        last_cycle;
  logic [4:0]  bit_count;
  logic [8:0]  shift_reg;
  logic [8:0]  rx_reg;
  logic [7:0]  dout_reg;
  logic        ack_reg;
  logic        done_reg;
  logic        is_read;
  logic        sda_hold;
  logic        scl_release;
  logic        sda_release;
  logic        accept_data;
  logic        sda_in;

  assign last_cycle  = (cnt == 16'(DVSR - 1));
  assign accept_data = (state == ST_HOLD) && i_wr_i2c &&
                       ((i_cmd == CMD_WR) || (i_cmd == CMD_RD));
  assign sda_in      = io_sda;

  // State register; reset drops straight to IDLE without a STOP.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= ST_IDLE;
    else         state <= state_next;
  end

  // Next-state and line levels; each timed state lasts one SCL quarter.
  always_comb begin
    state_next  = state;
    scl_release = 1'b1;
    sda_release = 1'b1;
    unique case (state)
      ST_IDLE: begin
        if (i_wr_i2c && (i_cmd == CMD_START)) state_next = ST_START1;
      end
      ST_START1: begin
        sda_release = 1'b0;
        if (last_cycle) state_next = ST_START2;
      end
      ST_START2: begin
        scl_release = 1'b0;
        sda_release = 1'b0;
        if (last_cycle) state_next = ST_HOLD;
      end
      ST_HOLD: begin
        scl_release = 1'b0;
        sda_release = sda_hold;
        if (i_wr_i2c) begin
          case (i_cmd)
            CMD_WR, CMD_RD:        state_next = ST_DATA1;
            CMD_START, CMD_RESTART: state_next = ST_RESTART;
            CMD_STOP:              state_next = ST_STOP1;
            default:               state_next = ST_HOLD;
          endcase
        end
      end
      ST_DATA1: begin
        scl_release = 1'b0;
        sda_release = shift_reg[8];
        if (last_cycle) state_next = ST_DATA2;
      end
      ST_DATA2: begin
        sda_release = shift_reg[8];
        if (last_cycle) state_next = ST_DATA3;
      end
      ST_DATA3: begin
        sda_release = shift_reg[8];
        if (last_cycle) state_next = ST_DATA4;
      end
      ST_DATA4: begin
        scl_release = 1'b0;
        sda_release = shift_reg[8];
        if (last_cycle) state_next = (bit_count == ACK_SLOT) ? ST_DATA_END : ST_DATA1;
      end
      ST_DATA_END: begin
        scl_release = 1'b0;
        sda_release = 1'b0;
        if (last_cycle) state_next = ST_HOLD;
      end
      ST_RESTART: begin
        if (last_cycle) state_next = ST_START1;
      end
      ST_STOP1: begin
        sda_release = 1'b0;
        if (last_cycle) state_next = ST_STOP2;
      end
      ST_STOP2: begin
        if (last_cycle) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath: dwell counter, byte shifting, sampling and result capture.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt       <= '0;
      bit_count <= '0;
      shift_reg <= '0;
      rx_reg    <= '0;
      dout_reg  <= '0;
      ack_reg   <= 1'b1;
      done_reg  <= 1'b0;
      is_read   <= 1'b0;
      sda_hold  <= 1'b1;
    end else begin
      done_reg <= 1'b0;
      if ((state_next != state) || (state == ST_IDLE) || (state == ST_HOLD)) cnt <= '0;
      else                                                                  cnt <= cnt + 16'd1;
      if (state != ST_HOLD) sda_hold <= sda_release;
      if (accept_data) begin
        shift_reg <= (i_cmd == CMD_RD) ? {8'hFF, i_din[0]} : {i_din, 1'b1};
        is_read   <= (i_cmd == CMD_RD);
        bit_count <= '0;
        rx_reg    <= '0;
      end
      if ((state == ST_DATA2) && last_cycle) rx_reg <= {rx_reg[7:0], sda_in};
      if ((state == ST_DATA4) && last_cycle && (bit_count != ACK_SLOT)) begin
        shift_reg <= {shift_reg[7:0], 1'b0};
        bit_count <= bit_count + 5'd1;
      end
      if ((state == ST_DATA_END) && last_cycle) begin
        done_reg <= 1'b1;
        if (is_read) dout_reg <= rx_reg[8:1];
        else         ack_reg  <= rx_reg[0];
      end
    end
  end

  i2c_open_drain u_sda_pad (.drive_low(!sda_release), .line(io_sda));
  i2c_open_drain u_scl_pad (.drive_low(!scl_release), .line(io_scl));

  assign o_dout      = dout_reg;
  assign o_ack       = ack_reg;
  assign o_done_tick = done_reg;
  assign o_ready     = (state == ST_IDLE) || (state == ST_HOLD);
  assign o_state     = state;
  assign o_bit_count = bit_count;

endmodule

// File: tb/tb_i2c_master_controller.sv
// Randomized bench for the I2C master with a bus monitor and a simple slave.
module tb_i2c_master_controller;
  import i2c_master_pkg::*;

  localparam int DVSR = 4;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_wr_i2c = 1'b0;
  logic [2:0] i_cmd = 3'b000;
  logic [7:0] i_din = 8'h00;
  logic [7:0] o_dout;
  logic       o_ack, o_ready, o_done_tick;
  logic [3:0] o_state;
  logic [4:0] o_bit_count;
  wire        sda_line, scl_line;

  pullup (sda_line);
  pullup (scl_line);

  i2c_master_controller #(.DVSR(DVSR)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_wr_i2c(i_wr_i2c), .i_cmd(i_cmd),
    .i_din(i_din), .o_dout(o_dout), .o_ack(o_ack), .o_ready(o_ready),
    .o_done_tick(o_done_tick), .o_state(o_state), .o_bit_count(o_bit_count),
    .io_sda(sda_line), .io_scl(scl_line)
  );

  always #5 i_clk = ~i_clk;

  // Slave: walks a 9-bit pattern MSB first, advancing on each SCL fall.
  logic       slave_on = 1'b0;
  logic [8:0] slave_pat = 9'h1FF;
  int         slave_base = 0;
  int         fall_total = 0;
  logic       slave_low;
  int         slave_idx;

  always_comb begin
    slave_low = 1'b0;
    slave_idx = fall_total - slave_base;
    if (slave_on && (slave_idx >= 0) && (slave_idx < 9)) slave_low = !slave_pat[8 - slave_idx];
  end

  assign sda_line = slave_low ? 1'b0 : 1'bz;

  // Bus monitor: START/STOP conditions, SDA at SCL rises, done pulses.
  int   start_count = 0, stop_count = 0, done_count = 0;
  logic prev_scl = 1'b1, prev_sda = 1'b1;
  logic rise_q[$];
  int   bc_q[$];

  always @(negedge i_clk) begin
    if (prev_scl && scl_line && prev_sda && !sda_line) start_count++;
    if (prev_scl && scl_line && !prev_sda && sda_line) stop_count++;
    if (!prev_scl && scl_line) begin
      rise_q.push_back(sda_line);
      bc_q.push_back(int'(o_bit_count));
    end
    if (prev_scl && !scl_line) fall_total++;
    if (o_done_tick) done_count++;
    prev_scl = scl_line;
    prev_sda = sda_line;
  end

  int n_checks = 0, n_pass = 0, n_fail = 0;
  logic       model_ack = 1'b1;
  logic [7:0] model_dout = 8'h00;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Issue one command and count the cycles until the master is ready again.
  task automatic applyStimulus(input logic [2:0] cmd, input logic [7:0] din, output int busy);
    @(negedge i_clk);
    checkOutput("ready_before_cmd", 32'(o_ready), 32'd1);
    i_wr_i2c = 1'b1;
    i_cmd    = cmd;
    i_din    = din;
    @(negedge i_clk);
    i_wr_i2c = 1'b0;
    i_cmd    = 3'($urandom);
    i_din    = 8'($urandom);
    busy = 0;
    while (!o_ready && busy < 2000) begin
      busy++;
      @(negedge i_clk);
    end
    #1;
  endtask

  // One byte transfer compared against the wired-AND of master and slave bits.
  task automatic doByte(input logic is_rd, input logic [7:0] data, input logic extra);
    int         busy, base_rise, base_done, bc_ok;
    logic [8:0] exp_bits, obs_bits;
    logic [7:0] din;
    base_rise = rise_q.size();
    base_done = done_count;
    if (is_rd) begin
      din       = {7'($urandom), extra};
      slave_pat = {data, 1'b1};
      exp_bits  = {data, extra};
      model_dout = data;
    end else begin
      din       = data;
      slave_pat = {8'hFF, extra};
      exp_bits  = {data, extra};
      model_ack = extra;
    end
    slave_base = fall_total;
    slave_on   = 1'b1;
    applyStimulus(is_rd ? CMD_RD : CMD_WR, din, busy);
    slave_on = 1'b0;
    checkOutput("byte_cycles", 32'(busy), 32'(37 * DVSR));
    checkOutput("done_pulses", 32'(done_count - base_done), 32'd1);
    obs_bits = '0;
    bc_ok = 0;
    for (int i = 0; i < 9; i++) begin
      if (base_rise + i < rise_q.size()) begin
        obs_bits = {obs_bits[7:0], rise_q[base_rise + i]};
        if (bc_q[base_rise + i] == i) bc_ok++;
      end
    end
    checkOutput("scl_rise_sda_bits", 32'(obs_bits), 32'(exp_bits));
    checkOutput("bit_count_seq", 32'(bc_ok), 32'd9);
    checkOutput("ack_out", 32'(o_ack), 32'(model_ack));
    checkOutput("dout_out", 32'(o_dout), 32'(model_dout));
    checkOutput("state_hold", 32'(o_state), 32'd3);
  endtask

  initial begin
    int busy, s0, p0;
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int busy, s0, p0;
    repeat (3) @(negedge i_clk);
    i_reset = 1'b0;
    repeat (20) @(negedge i_clk);
    checkOutput("reset_state", 32'(o_state), 32'd0);
    checkOutput("reset_ready", 32'(o_ready), 32'd1);
    checkOutput("reset_sda", 32'(sda_line), 32'd1);
    checkOutput("reset_scl", 32'(scl_line), 32'd1);
    checkOutput("reset_ack", 32'(o_ack), 32'd1);
    checkOutput("reset_dout", 32'(o_dout), 32'd0);
    checkOutput("reset_done", 32'(o_done_tick), 32'd0);

    // Data commands are ignored while the bus is idle.
    i_wr_i2c = 1'b1; i_cmd = CMD_WR; i_din = 8'h55;
    @(negedge i_clk);
    i_wr_i2c = 1'b0;
    repeat (3) @(negedge i_clk);
    checkOutput("idle_ignores_wr", 32'(o_state), 32'd0);

    s0 = start_count;
    applyStimulus(CMD_START, 8'h00, busy);
    checkOutput("start_cycles", 32'(busy), 32'(2 * DVSR));
    checkOutput("start_condition", 32'(start_count - s0), 32'd1);
    checkOutput("start_state", 32'(o_state), 32'd3);

    // Undefined command codes leave HOLD untouched.
    for (int k = 0; k < 3; k++) begin
      i_wr_i2c = 1'b1;
      i_cmd = (k == 0) ? 3'b000 : ((k == 1) ? 3'b110 : 3'b111);
      @(negedge i_clk);
      i_wr_i2c = 1'b0;
      repeat (2) @(negedge i_clk);
      checkOutput("hold_ignores_invalid", 32'(o_state), 32'd3);
    end

    doByte(1'b0, 8'hFF, 1'b1);
    doByte(1'b0, 8'hAA, 1'b0);
    for (int k = 0; k < 6; k++) doByte(1'b0, 8'($urandom), 1'($urandom));

    s0 = start_count;
    applyStimulus(CMD_RESTART, 8'h00, busy);
    checkOutput("restart_cycles", 32'(busy), 32'(3 * DVSR));
    checkOutput("restart_condition", 32'(start_count - s0), 32'd1);
    doByte(1'b0, 8'($urandom), 1'($urandom));

    p0 = stop_count;
    applyStimulus(CMD_STOP, 8'h00, busy);
    checkOutput("stop_cycles", 32'(busy), 32'(2 * DVSR));
    checkOutput("stop_condition", 32'(stop_count - p0), 32'd1);
    checkOutput("stop_state", 32'(o_state), 32'd0);
    checkOutput("stop_sda", 32'(sda_line), 32'd1);
    checkOutput("stop_scl", 32'(scl_line), 32'd1);

    applyStimulus(CMD_START, 8'h00, busy);
    for (int k = 0; k < 5; k++) doByte(1'b1, 8'($urandom), 1'($urandom));
    doByte(1'b1, 8'h5C, 1'b1);

    // Reset in the middle of a read aborts it at once.
    s0 = done_count;
    p0 = stop_count;
    slave_pat  = 9'h0A5;
    slave_base = fall_total;
    slave_on   = 1'b1;
    @(negedge i_clk);
    i_wr_i2c = 1'b1; i_cmd = CMD_RD; i_din = 8'h01;
    @(negedge i_clk);
    i_wr_i2c = 1'b0;
    repeat (50) @(negedge i_clk);
    #2;
    i_reset  = 1'b1;
    slave_on = 1'b0;
    #1;
    checkOutput("abort_state", 32'(o_state), 32'd0);
    checkOutput("abort_scl", 32'(scl_line), 32'd1);
    checkOutput("abort_sda", 32'(sda_line), 32'd1);
    checkOutput("abort_ready", 32'(o_ready), 32'd1);
    checkOutput("abort_dout", 32'(o_dout), 32'd0);
    checkOutput("abort_ack", 32'(o_ack), 32'd1);
    checkOutput("abort_bit_count", 32'(o_bit_count), 32'd0);
    repeat (3) @(negedge i_clk);
    i_reset = 1'b0;
    repeat (10) @(negedge i_clk);
    #1;
    checkOutput("abort_no_done", 32'(done_count - s0), 32'd0);
    checkOutput("abort_idle", 32'(o_state), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/i2c_master_controller.md
I2C_MASTER_CONTROLLER -- requirements
Module: i2c_master_controller

Interface
REQ-001 SHALL have parameter DVSR, default 4, meaning system-clock cycles per SCL quarter-period (legal 2..65535).
REQ-002 SHALL have port i_clk, input, 1, the single system clock; all logic on its rising edge.
REQ-003 SHALL have port i_reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port i_wr_i2c, input, 1, command strobe; sampled only while o_ready=1.
REQ-005 SHALL have port i_cmd, input, 3, command: START=001, WR=010, RD=011, STOP=100, RESTART=101.
REQ-006 SHALL have port i_din, input, 8, write byte for WR; bit 0 is the ACK/NACK value driven after RD (0=ACK, 1=NACK).
REQ-007 SHALL have port o_dout, output, 8, last byte received by RD.
REQ-008 SHALL have port o_ack, output, 1, ACK bit sampled from slave after WR (0=ACK).
REQ-009 SHALL have port o_ready, output, 1, high only in IDLE and HOLD.
REQ-010 SHALL have port o_done_tick, output, 1, one-cycle pulse on completion of each WR/RD byte.
REQ-011 SHALL have port o_state, output, 4, current FSM state encoding.
REQ-012 SHALL have port o_bit_count, output, 5, bit index within current byte (0..8, bit 8 = ACK slot).
REQ-013 SHALL have ports io_sda and io_scl, inout, 1 each, open-drain: drive 0 or high-Z, never 1.

Function
REQ-014 SHALL use state encoding IDLE=0, START1=1, START2=2, HOLD=3, DATA1=4, DATA2=5, DATA3=6, DATA4=7, DATA_END=8, RESTART=9, STOP1=10, STOP2=11.
REQ-015 SHALL dwell DVSR cycles in every non-IDLE/HOLD state using an internal 16-bit counter cleared on each state change.
REQ-016 IDLE: SCL, SDA released; i_wr_i2c with START -> START1; any other command ignored.
REQ-017 START1: SCL released, SDA low (START condition); then START2: SCL low, SDA low; then HOLD.
REQ-018 HOLD: SCL low, SDA held at last driven value; i_wr_i2c with WR/RD -> DATA1 with bit count 0; RESTART or START -> RESTART; STOP -> STOP1; invalid codes ignored.
REQ-019 On WR/RD acceptance, SHALL latch a 9-bit shift register: WR = {i_din, 1} (ACK slot released); RD = {8'hFF, i_din[0]}.
REQ-020 Each bit, MSB first: DATA1 SCL low, SDA set to shift-register MSB (1 = release); DATA2 and DATA3 SCL released; SDA sampled at end of DATA2; DATA4 SCL low; then shift and increment bit count.
REQ-021 After bit 8 DATA4 -> DATA_END (SCL low, SDA low) -> HOLD; o_done_tick pulses on the DATA_END->HOLD transition.
REQ-022 On completion, RD SHALL load o_dout with the 8 sampled data bits; WR SHALL load o_ack with the sampled ACK bit; the other output keeps its value.
REQ-023 RESTART: SDA released, SCL released for DVSR cycles -> START1.
REQ-024 STOP1: SCL released, SDA low; STOP2: SCL released, SDA released (STOP condition); then IDLE.
REQ-025 i_cmd/i_din SHALL be read only on the acceptance cycle; later changes do not affect the transfer in progress.
REQ-026 SHALL not check for clock stretching or arbitration loss.

Reset
REQ-027 i_reset=1 SHALL immediately force IDLE, release both lines, clear counters, bit count, shift register, o_dout, o_done_tick to 0, o_ack to 1; o_ready=1 after reset.
REQ-028 Reset mid-byte SHALL abort the transfer with no STOP generated and no o_done_tick.

Structure
REQ-029 Command codes and state encodings SHALL live in shared package i2c_master_pkg.
REQ-030 SHALL be one module; optional sub-module i2c_open_drain (tri-state buffer) per line.

Verification
REQ-031 Reset then idle 20 cycles -> o_state=0, o_ready=1, io_sda=io_scl=1 (pull-ups).
REQ-032 START, DVSR=4 -> SDA falls while SCL high; o_state reaches 3 after 8 cycles; o_ready=1.
REQ-033 WR 8'hFF with no slave -> SDA released all 9 bits, o_ack=1, o_done_tick one cycle, o_bit_count counts 0..8.
REQ-034 WR 8'hAA -> SDA at each SCL rise 1,0,1,0,1,0,1,0 then released; 36 SCL-quarter periods plus DATA_END.
REQ-035 RESTART then WR then STOP -> repeated START (SDA falls, SCL high), byte sent, SDA rises while SCL high, o_state returns 0.
REQ-036 RD with slave driving 8'h5C, i_din[0]=1 -> o_dout=8'h5C, master releases SDA in ACK slot; reset asserted mid-byte -> IDLE within 0 cycles, lines released.
